// File: rtl/lcm_parser.sv
// lcm_parser: turns a framed flit stream (head / middle / tail) into
// single-cycle register read or write command pulses. The command is taken
// from the head flit and emitted only after a keep verdict arrives.
// Optional build macro LCM_PARSER_LEN_CHECK_EN: also discard packets longer
// than MAX_FLITS flits, using a saturating flit counter.
module lcm_parser #(
    parameter int MAX_FLITS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] in_lcm_data,
    input  logic         in_lcm_data_wr,
    input  logic         in_lcm_data_valid,
    input  logic         in_lcm_data_valid_wr,
    output logic         in_lcm_data_ready,
    output logic [7:0]   wr_reg_n,
    output logic [63:0]  wr_reg_n_value,
    output logic [7:0]   rd_reg_n
);

    localparam logic [1:0] FR_HEAD = 2'b01;
    localparam logic [1:0] FR_MID  = 2'b11;
    localparam logic [1:0] FR_TAIL = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BODY       = 2'd1,
        WAIT_VALID = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_reg;
    logic [63:0] r_value;
    logic        r_op;

    logic [1:0]  w_frame;
    logic        w_flit;
    logic        w_len_ok;
    logic        w_emit;

    // Reserved and ignored fields are intentionally not used.
    logic        w_unused_bits;
    assign w_unused_bits = ^{in_lcm_data[131:128], in_lcm_data[55:49], in_lcm_data[47:0]};

    assign w_frame           = in_lcm_data[133:132];
    assign in_lcm_data_ready = (r_state != WAIT_VALID);
    // Flits arriving while not ready are simply dropped.
    assign w_flit            = in_lcm_data_wr & in_lcm_data_ready;

`ifdef LCM_PARSER_LEN_CHECK_EN
    localparam int              CNT_W   = $clog2(MAX_FLITS + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_FLITS + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_FLITS);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    // Counter sticks at MAX_FLITS+1 so an overlong packet can never wrap back to legal.
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
    assign w_len_ok  = (r_cnt <= CNT_LIM);

    // Flit counter: restart on every accepted head, count middle/tail in BODY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_flit) begin
            if (w_frame == FR_HEAD) begin
                r_cnt <= CNT_W'(1);
            end else if (r_state == BODY && (w_frame == FR_MID || w_frame == FR_TAIL)) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end
`else
    assign w_len_ok = 1'b1;
`endif

    // Register 0 is reserved, so a command aimed at it never pulses.
    assign w_emit = (r_state == WAIT_VALID) & in_lcm_data_valid_wr & in_lcm_data_valid
                  & w_len_ok & (r_reg != 8'd0);

    // Packet FSM with command latches and registered single-cycle output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_reg          <= '0;
            r_value        <= '0;
            r_op           <= 1'b0;
            wr_reg_n       <= '0;
            wr_reg_n_value <= '0;
            rd_reg_n       <= '0;
        end else begin
            // Outputs default back to zero; only an emit cycle drives them.
            wr_reg_n       <= '0;
            wr_reg_n_value <= '0;
            rd_reg_n       <= '0;
            case (r_state)
                IDLE: begin
                    if (w_flit && w_frame == FR_HEAD) begin
                        r_reg   <= in_lcm_data[127:120];
                        r_value <= in_lcm_data[119:56];
                        r_op    <= in_lcm_data[48];
                        r_state <= BODY;
                    end
                end
                BODY: begin
                    if (w_flit) begin
                        if (w_frame == FR_HEAD) begin
                            // A new head abandons the packet in progress.
                            r_reg   <= in_lcm_data[127:120];
                            r_value <= in_lcm_data[119:56];
                            r_op    <= in_lcm_data[48];
                        end else if (w_frame == FR_TAIL) begin
                            r_state <= WAIT_VALID;
                        end
                    end
                end
                WAIT_VALID: begin
                    if (in_lcm_data_valid_wr) begin
                        r_state <= IDLE;
                        if (w_emit) begin
                            if (r_op) begin
                                rd_reg_n <= r_reg;
                            end else begin
                                wr_reg_n       <= r_reg;
                                wr_reg_n_value <= r_value;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_parser.sv
// Directed bench for lcm_parser with hand-computed expected pulses.
module tb_lcm_parser;

    localparam logic [1:0] FR_HEAD = 2'b01;
    localparam logic [1:0] FR_MID  = 2'b11;
    localparam logic [1:0] FR_TAIL = 2'b10;

    logic         clk;
    logic         rst_n;
    logic [133:0] in_lcm_data;
    logic         in_lcm_data_wr;
    logic         in_lcm_data_valid;
    logic         in_lcm_data_valid_wr;
    logic         in_lcm_data_ready;
    logic [7:0]   wr_reg_n;
    logic [63:0]  wr_reg_n_value;
    logic [7:0]   rd_reg_n;

    int n_chk  = 0;
    int n_pass = 0;

    lcm_parser #(.MAX_FLITS(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_lcm_data          (in_lcm_data),
        .in_lcm_data_wr       (in_lcm_data_wr),
        .in_lcm_data_valid    (in_lcm_data_valid),
        .in_lcm_data_valid_wr (in_lcm_data_valid_wr),
        .in_lcm_data_ready    (in_lcm_data_ready),
        .wr_reg_n             (wr_reg_n),
        .wr_reg_n_value       (wr_reg_n_value),
        .rd_reg_n             (rd_reg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [133:0] mk(input logic [1:0] fr, input logic [7:0] rg,
                                        input logic [63:0] v, input logic op);
        logic [133:0] d;
        d          = '0;
        d[133:132] = fr;
        d[127:120] = rg;
        d[119:56]  = v;
        d[48]      = op;
        d[47:0]    = 48'hDEAD_BEEF_CAFE;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] fr, input logic [7:0] rg, input logic [63:0] v, input logic op);
        in_lcm_data    = mk(fr, rg, v, op);
        in_lcm_data_wr = 1'b1;
        step();
        in_lcm_data_wr = 1'b0;
        in_lcm_data    = '0;
    endtask

    // Head, nmid middles carrying decoy contents, tail; then expect WAIT_VALID.
    task automatic pkt(input string tag, input logic [7:0] rg, input logic [63:0] v, input logic op, input int nmid);
        send(FR_HEAD, rg, v, op);
        for (int i = 0; i < nmid; i++) send(FR_MID, 8'h15, 64'h2345, ~op);
        send(FR_TAIL, 8'h77, 64'h99, ~op);
        chk({tag, "_rdy_wait"}, 64'(in_lcm_data_ready), 64'd0);
    endtask

    task automatic verdict(input logic v);
        in_lcm_data_valid_wr = 1'b1;
        in_lcm_data_valid    = v;
        step();
        in_lcm_data_valid_wr = 1'b0;
        in_lcm_data_valid    = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [7:0] wr, input logic [63:0] val, input logic [7:0] rd);
        chk({tag, "_wr"},  64'(wr_reg_n), 64'(wr));
        chk({tag, "_val"}, wr_reg_n_value, val);
        chk({tag, "_rd"},  64'(rd_reg_n), 64'(rd));
    endtask

    initial begin
        rst_n                = 1'b0;
        in_lcm_data          = '0;
        in_lcm_data_wr       = 1'b0;
        in_lcm_data_valid    = 1'b0;
        in_lcm_data_valid_wr = 1'b0;
        repeat (3) step();
        chk("rst_ready", 64'(in_lcm_data_ready), 64'd1);
        outs("rst", 8'h0, 64'h0, 8'h0);
        rst_n = 1'b1;
        step();

        // Read packet
        pkt("rd", 8'h01, 64'h0, 1'b1, 4);
        verdict(1'b1);
        outs("rd_pulse", 8'h0, 64'h0, 8'h01);
        chk("rd_rdy_idle", 64'(in_lcm_data_ready), 64'd1);
        step();
        outs("rd_after", 8'h0, 64'h0, 8'h0);

        // Write packet, middles carry reg 0x15 / 0x2345 which must be ignored
        pkt("wr", 8'h01, 64'h7, 1'b0, 5);
        verdict(1'b1);
        outs("wr_pulse", 8'h01, 64'h7, 8'h0);
        step();
        outs("wr_after", 8'h0, 64'h0, 8'h0);

        // Discard verdict, then a normal packet
        pkt("disc", 8'h01, 64'h7, 1'b0, 5);
        verdict(1'b0);
        outs("disc_pulse", 8'h0, 64'h0, 8'h0);
        pkt("post", 8'h22, 64'h0, 1'b1, 1);
        verdict(1'b1);
        outs("post_pulse", 8'h0, 64'h0, 8'h22);

        // Back-to-back: head sent in the cycle right after each verdict
        pkt("b2b1", 8'h01, 64'h0, 1'b1, 2);
        verdict(1'b1);
        outs("b2b1_pulse", 8'h0, 64'h0, 8'h01);
        chk("b2b1_rdy", 64'(in_lcm_data_ready), 64'd1);
        pkt("b2b2", 8'h01, 64'hAA, 1'b0, 2);
        verdict(1'b1);
        outs("b2b2_pulse", 8'h01, 64'hAA, 8'h0);
        chk("b2b2_rdy", 64'(in_lcm_data_ready), 64'd1);
        pkt("b2b3", 8'h01, 64'h0, 1'b1, 0);
        verdict(1'b1);
        outs("b2b3_pulse", 8'h0, 64'h0, 8'h01);
        step();
        outs("b2b_after", 8'h0, 64'h0, 8'h0);

        // Flit during WAIT_VALID is dropped
        pkt("drop", 8'h10, 64'h0, 1'b1, 1);
        send(FR_HEAD, 8'h33, 64'h5, 1'b0);
        chk("drop_rdy", 64'(in_lcm_data_ready), 64'd0);
        verdict(1'b1);
        outs("drop_pulse", 8'h0, 64'h0, 8'h10);

        // Second head in BODY restarts with the new command
        send(FR_HEAD, 8'h40, 64'h1, 1'b1);
        send(FR_MID, 8'h15, 64'h2345, 1'b1);
        pkt("restart", 8'h41, 64'h55, 1'b0, 1);
        verdict(1'b1);
        outs("restart_pulse", 8'h41, 64'h55, 8'h0);

        // Verdict strobe during BODY is ignored
        send(FR_HEAD, 8'h50, 64'h0, 1'b1);
        verdict(1'b1);
        outs("body_vwr", 8'h0, 64'h0, 8'h0);
        chk("body_vwr_rdy", 64'(in_lcm_data_ready), 64'd1);
        send(FR_TAIL, 8'h0, 64'h0, 1'b0);
        chk("body_vwr_wait", 64'(in_lcm_data_ready), 64'd0);
        verdict(1'b1);
        outs("body_vwr_pulse", 8'h0, 64'h0, 8'h50);

        // Register 0 never pulses
        pkt("reg0", 8'h00, 64'h9, 1'b0, 1);
        verdict(1'b1);
        outs("reg0_pulse", 8'h0, 64'h0, 8'h0);

        // Non-head flits in IDLE are ignored, verdict in IDLE ignored
        send(FR_MID, 8'h61, 64'h1, 1'b1);
        send(FR_TAIL, 8'h61, 64'h1, 1'b1);
        chk("idle_nonhead_rdy", 64'(in_lcm_data_ready), 64'd1);
        verdict(1'b1);
        outs("idle_vwr", 8'h0, 64'h0, 8'h0);

        // Reset mid-packet discards the packet
        send(FR_HEAD, 8'h60, 64'h0, 1'b1);
        send(FR_MID, 8'h0, 64'h0, 1'b1);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
        send(FR_TAIL, 8'h0, 64'h0, 1'b1);
        chk("rstmid_rdy", 64'(in_lcm_data_ready), 64'd1);
        verdict(1'b1);
        outs("rstmid_pulse", 8'h0, 64'h0, 8'h0);

`ifdef LCM_PARSER_LEN_CHECK_EN
        // 33 flits: over the limit, discarded; 32 flits: accepted
        pkt("len33", 8'h70, 64'h0, 1'b1, 31);
        verdict(1'b1);
        outs("len33_pulse", 8'h0, 64'h0, 8'h0);
        pkt("len32", 8'h71, 64'h0, 1'b1, 30);
        verdict(1'b1);
        outs("len32_pulse", 8'h0, 64'h0, 8'h71);
`else
        // Length has no effect without the length check
        pkt("len33", 8'h70, 64'h0, 1'b1, 31);
        verdict(1'b1);
        outs("len33_pulse", 8'h0, 64'h0, 8'h70);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
